// File: rtl/hs_bus_sync.sv
// hs_bus_sync: 4-phase req/ack synchroniser moving one held word from clk1 to clk2.
// Define HS_DROP_CNT_EN to add the saturating drop_cnt of offers refused while busy.
module hs_bus_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              clk2,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              dst_valid,
  output logic [DATA_W-1:0] dst_data,
  output logic              busy
`ifdef HS_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_data_w
    $error("hs_bus_sync: DATA_W out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("hs_bus_sync: SYNC_STAGES out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hs_bus_sync: CNT_W out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              load;
  logic              req_q;
  logic              req_d;
  logic [DATA_W-1:0] hold_q;

  logic [SYNC_STAGES-1:0] ack_pipe;
  logic                   ack_sync;

  logic [SYNC_STAGES-1:0] req_pipe;
  logic                   req_sync;
  logic                   ack_q;
  logic                   rise;
  logic                   dst_valid_q;
  logic [DATA_W-1:0]      dst_data_q;

  // Source domain
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (src_valid) begin
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_sync) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!ack_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      if (load) hold_q <= src_data;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) ack_pipe <= '0;
    else        ack_pipe <= {ack_pipe[SYNC_STAGES-2:0], ack_q};
  end

  assign ack_sync  = ack_pipe[SYNC_STAGES-1];
  assign src_ready = (state_q == S_IDLE);
  assign busy      = ~src_ready;

`ifdef HS_DROP_CNT_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (src_valid && busy && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`endif

  // Destination domain; ack doubles as the previous req_sync for edge detect
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) req_pipe <= '0;
    else        req_pipe <= {req_pipe[SYNC_STAGES-2:0], req_q};
  end

  assign req_sync = req_pipe[SYNC_STAGES-1];
  assign rise     = req_sync & ~ack_q;

  // hold_q has been frozen for SYNC_STAGES clk2 cycles when rise fires
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
    end else begin
      ack_q       <= req_sync;
      dst_valid_q <= rise;
      if (rise) dst_data_q <= hold_q;
    end
  end

  assign dst_valid = dst_valid_q;
  assign dst_data  = dst_data_q;

endmodule

// File: tb/tb_hs_bus_sync.sv
// tb_hs_bus_sync: random/directed transfers across varying clock ratios,
// checked against an in-order queue of words the bench offered and saw accepted.
`timescale 1ns/1ps
module tb_hs_bus_sync;

  logic       clk1 = 1'b0;
  logic       clk2 = 1'b0;
  logic       rst_n = 1'b0;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic       src_ready;
  logic       dst_valid;
  logic [7:0] dst_data;
  logic       busy;
`ifdef HS_DROP_CNT_EN
  logic [7:0] drop_cnt;
  logic [1:0] drop_cnt2;
  logic       src_ready2;
  logic       dst_valid2;
  logic [7:0] dst_data2;
  logic       busy2;
`endif

  int         total = 0;
  int         bad = 0;
  int         acc_cnt = 0;
  int         rx_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rx = 8'h00;
  real        h1 = 5.0;
  real        h2 = 18.52;
  bit         jit_en = 1'b0;

  hs_bus_sync #(
    .DATA_W(8),
    .SYNC_STAGES(2),
    .CNT_W(8)
  ) dut (
    .clk1(clk1),
    .rst_n(rst_n),
    .clk2(clk2),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .dst_valid(dst_valid),
    .dst_data(dst_data),
    .busy(busy)
`ifdef HS_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

`ifdef HS_DROP_CNT_EN
  hs_bus_sync #(
    .DATA_W(8),
    .SYNC_STAGES(2),
    .CNT_W(2)
  ) dut2 (
    .clk1(clk1),
    .rst_n(rst_n),
    .clk2(clk2),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready2),
    .dst_valid(dst_valid2),
    .dst_data(dst_data2),
    .busy(busy2),
    .drop_cnt(drop_cnt2)
  );
`endif

  initial forever begin
    #(h1);
    clk1 = ~clk1;
  end

  initial begin
    #3.7;
    forever begin
      #(h2 + (jit_en ? $urandom_range(0, 100) * h2 * 0.003 : 0.0));
      clk2 = ~clk2;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every pulse must match the oldest outstanding accepted word
  always @(negedge clk2) begin
    if (!rst_n) begin
      last_rx = 8'h00;
    end else if (dst_valid === 1'b1) begin
      rx_cnt++;
      chk("pending_at_pulse", exp_q.size(), 1);
      if (exp_q.size() != 0) chk("dst_data", dst_data, exp_q.pop_front());
      last_rx = dst_data;
    end else begin
      chk("dst_data_hold", dst_data, last_rx);
    end
  end

  task automatic send(input logic [7:0] d, input bit hold);
    bit ok = 1'b0;
    @(posedge clk1);
    #1;
    src_valid = 1'b1;
    src_data  = d;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk1);
      if (src_ready === 1'b1) begin
        exp_q.push_back(d);
        acc_cnt++;
        ok = 1'b1;
      end
      @(posedge clk1);
      #1;
    end
    if (!hold) src_valid = 1'b0;
    chk("accept_timeout", ok, 1);
  endtask

  task automatic quiesce();
    int n = 0;
    while ((exp_q.size() != 0 || src_ready !== 1'b1) && n < 5000) begin
      @(negedge clk1);
      n++;
    end
    repeat (4) @(negedge clk2);
    chk("quiesce_timeout", n < 5000, 1);
    chk("ready_at_quiesce", src_ready, 1);
    chk("busy_at_quiesce", busy, 0);
  endtask

  task automatic drops(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk1);
      #1;
      chk("busy_during_drop", busy, 1);
      src_valid = 1'b1;
      src_data  = 8'hE0 + 8'(i);
      @(posedge clk1);
      #1;
      src_valid = 1'b0;
    end
  endtask

  initial begin
    int rxb;
    logic [7:0] w;
    bit hold;

    repeat (3) @(negedge clk1);
    chk("rst_src_ready", src_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dst_valid", dst_valid, 0);
    chk("rst_dst_data", dst_data, 0);
`ifdef HS_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    @(posedge clk1);
    #1;
    rst_n = 1'b1;

    send(8'hA5, 1'b0);
    quiesce();
    chk("a5_count", rx_cnt, 1);
    chk("a5_data", dst_data, 8'hA5);
    repeat (20) @(negedge clk1);
    chk("a5_no_second", rx_cnt, 1);

    send(8'h11, 1'b0);
    drops(5);
    quiesce();
    chk("drop_only_first", rx_cnt, 2);
`ifdef HS_DROP_CNT_EN
    chk("drop_cnt_5", drop_cnt, 5);
`endif
    send(8'h22, 1'b0);
    drops(5);
    quiesce();
    chk("drop2_only_first", rx_cnt, 3);
`ifdef HS_DROP_CNT_EN
    chk("drop_cnt_10", drop_cnt, 10);
    chk("drop_cnt_sat", drop_cnt2, 3);
`endif

    rxb = rx_cnt;
    for (int i = 1; i <= 20; i++) send(8'(i), 1'b1);
    src_valid = 1'b0;
    quiesce();
    chk("b2b_count", rx_cnt, rxb + 20);
    chk("b2b_last", last_rx, 20);

    h1 = 20.0;
    h2 = 2.5;
    rxb = rx_cnt;
    for (int i = 0; i < 100; i++) begin
      w    = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      send(w, hold);
      if (!hold) repeat ($urandom_range(0, 4)) @(negedge clk1);
    end
    src_valid = 1'b0;
    quiesce();
    chk("slow_fast_count", rx_cnt, rxb + 100);

    h1 = 5.0;
    h2 = 18.52;
    repeat (4) @(negedge clk2);
    send(8'h77, 1'b0);
    chk("mid_in_req", busy, 1);
    exp_q.delete();
    acc_cnt--;
    rst_n = 1'b0;
    repeat (3) @(negedge clk2);
    chk("mid_rst_ready", src_ready, 1);
    chk("mid_rst_valid", dst_valid, 0);
    chk("mid_rst_data", dst_data, 0);
`ifdef HS_DROP_CNT_EN
    chk("mid_rst_drop", drop_cnt, 0);
`endif
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
    rxb = rx_cnt;
    repeat (40) @(negedge clk1);
    chk("no_stale_pulse", rx_cnt, rxb);
    chk("ready_after_rst", src_ready, 1);
    send(8'h3C, 1'b0);
    quiesce();
    chk("post_rst_count", rx_cnt, rxb + 1);
    chk("post_rst_data", last_rx, 8'h3C);

    jit_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) begin
        h1 = $urandom_range(20, 250) / 10.0;
        h2 = $urandom_range(20, 250) / 10.0;
      end
      w    = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      send(w, hold);
      if (!hold) repeat ($urandom_range(0, 5)) @(negedge clk1);
    end
    src_valid = 1'b0;
    quiesce();
    chk("accepts_eq_pulses", rx_cnt, acc_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
